iic_slave_core: RTL and testbench

//  I2C target (slave) answering one 7-bit device address, backed by a 2**REG_AW x 8 register file.
//  The same register file is readable and writable from the Avalon-MM slave side.

---
 rtl/iic_slave_core.sv | 232 +++++++++++++++++++++++
 tb/tb_iic_slave_core.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_slave_core.sv
// I2C target answering one 7-bit device address, backed by a 2**REG_AW x 8 register file
// that is also readable and writable from an Avalon-MM slave port.
module iic_slave_core #(
   parameter logic [6:0] DEV_ADDR = 7'h50,
   parameter int         REG_AW   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] address,
   input  logic              chipselect,
   input  logic              write,
   input  logic [31:0]       writedata,
   input  logic              read,
   output logic [31:0]       readdata,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic              sda_out
);

   localparam int NREG = 2 ** REG_AW;
   localparam logic [REG_AW-1:0] PTR_ONE = {{(REG_AW-1){1'b0}}, 1'b1};

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_ADDR     = 4'd1;
   localparam logic [3:0] S_ADDR_ACK = 4'd2;
   localparam logic [3:0] S_PTR      = 4'd3;
   localparam logic [3:0] S_WDATA    = 4'd4;
   localparam logic [3:0] S_WACK     = 4'd5;
   localparam logic [3:0] S_RDATA    = 4'd6;
   localparam logic [3:0] S_RACK     = 4'd7;
   localparam logic [3:0] S_WAIT     = 4'd8;

   logic              sclMeta_q, sclSync_q, sclPrev_q;
   logic              sdaMeta_q, sdaSync_q, sdaPrev_q;
   logic              sclRise, sclFall, startCond, stopCond;

   logic [3:0]        state_q, state_d;
   logic [3:0]        bitCnt_q, bitCnt_d;
   logic [7:0]        shift_q, shift_d;
   logic [REG_AW-1:0] ptr_q, ptr_d;
   logic              sdaOut_q, sdaOut_d;
   logic              ackOn_q, ackOn_d;
   logic              rw_q, rw_d;
   logic [7:0]        regs_q [NREG];
   logic [31:0]       readdata_q;
   logic [7:0]        rxByte, ptrByte;
   logic              i2cWe;
   logic              unusedWritedata;

   assign unusedWritedata = ^writedata[31:8];

   // Synchronisers come out of reset at the idle-bus level so no false edge is seen.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclMeta_q <= 1'b1;
         sclSync_q <= 1'b1;
         sclPrev_q <= 1'b1;
         sdaMeta_q <= 1'b1;
         sdaSync_q <= 1'b1;
         sdaPrev_q <= 1'b1;
      end else begin
         sclMeta_q <= scl_in;
         sclSync_q <= sclMeta_q;
         sclPrev_q <= sclSync_q;
         sdaMeta_q <= sda_in;
         sdaSync_q <= sdaMeta_q;
         sdaPrev_q <= sdaSync_q;
      end
   end

   assign sclRise   = sclSync_q & ~sclPrev_q;
   assign sclFall   = ~sclSync_q & sclPrev_q;
   assign startCond = sclSync_q & sclPrev_q & sdaPrev_q & ~sdaSync_q;
   assign stopCond  = sclSync_q & sclPrev_q & ~sdaPrev_q & sdaSync_q;
   assign rxByte    = {shift_q[6:0], sdaSync_q};
   assign ptrByte   = regs_q[ptr_q];

   // ackOn_q marks the driven half of an ACK slot; in RACK it records the master's ACK.
   always_comb begin
      state_d  = state_q;
      bitCnt_d = bitCnt_q;
      shift_d  = shift_q;
      ptr_d    = ptr_q;
      sdaOut_d = sdaOut_q;
      ackOn_d  = ackOn_q;
      rw_d     = rw_q;
      i2cWe    = 1'b0;
      if (startCond) begin
         state_d  = S_ADDR;
         bitCnt_d = '0;
         sdaOut_d = 1'b1;
         ackOn_d  = 1'b0;
      end else if (stopCond) begin
         state_d  = S_IDLE;
         bitCnt_d = '0;
         sdaOut_d = 1'b1;
         ackOn_d  = 1'b0;
      end else begin
         case (state_q)
            S_ADDR, S_PTR, S_WDATA: begin
               if (sclRise) begin
                  shift_d  = rxByte;
                  bitCnt_d = bitCnt_q + 4'd1;
                  if (bitCnt_q == 4'd7) begin
                     bitCnt_d = '0;
                     ackOn_d  = 1'b0;
                     if (state_q == S_ADDR) begin
                        if (rxByte[7:1] == DEV_ADDR) begin
                           state_d = S_ADDR_ACK;
                           rw_d    = rxByte[0];
                        end else begin
                           state_d = S_WAIT;
                        end
                     end else if (state_q == S_PTR) begin
                        ptr_d   = rxByte[REG_AW-1:0];
                        state_d = S_WACK;
                     end else begin
                        i2cWe   = 1'b1;
                        ptr_d   = ptr_q + PTR_ONE;
                        state_d = S_WACK;
                     end
                  end
               end
            end
            S_ADDR_ACK, S_WACK: begin
               if (sclFall) begin
                  if (!ackOn_q) begin
                     sdaOut_d = 1'b0;
                     ackOn_d  = 1'b1;
                  end else begin
                     sdaOut_d = 1'b1;
                     ackOn_d  = 1'b0;
                     bitCnt_d = '0;
                     if (state_q == S_WACK) begin
                        state_d = S_WDATA;
                     end else if (!rw_q) begin
                        state_d = S_PTR;
                     end else begin
                        state_d  = S_RDATA;
                        sdaOut_d = ptrByte[7];
                        shift_d  = {ptrByte[6:0], 1'b1};
                        ptr_d    = ptr_q + PTR_ONE;
                     end
                  end
               end
            end
            S_RDATA: begin
               if (sclRise) begin
                  bitCnt_d = bitCnt_q + 4'd1;
               end else if (sclFall) begin
                  if (bitCnt_q == 4'd8) begin
                     sdaOut_d = 1'b1;
                     bitCnt_d = '0;
                     ackOn_d  = 1'b0;
                     state_d  = S_RACK;
                  end else begin
                     sdaOut_d = shift_q[7];
                     shift_d  = {shift_q[6:0], 1'b1};
                  end
               end
            end
            S_RACK: begin
               if (sclRise) begin
                  if (!sdaSync_q) begin
                     ackOn_d = 1'b1;
                  end else begin
                     state_d = S_WAIT;
                  end
               end else if (sclFall && ackOn_q) begin
                  ackOn_d  = 1'b0;
                  bitCnt_d = '0;
                  state_d  = S_RDATA;
                  sdaOut_d = ptrByte[7];
                  shift_d  = {ptrByte[6:0], 1'b1};
                  ptr_d    = ptr_q + PTR_ONE;
               end
            end
            S_IDLE, S_WAIT: begin
               sdaOut_d = 1'b1;
            end
            default: begin
               state_d  = S_IDLE;
               sdaOut_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         bitCnt_q <= '0;
         shift_q  <= '0;
         ptr_q    <= '0;
         sdaOut_q <= 1'b1;
         ackOn_q  <= 1'b0;
         rw_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitCnt_q <= bitCnt_d;
         shift_q  <= shift_d;
         ptr_q    <= ptr_d;
         sdaOut_q <= sdaOut_d;
         ackOn_q  <= ackOn_d;
         rw_q     <= rw_d;
      end
   end

   // The I2C write is issued last so it wins a same-cycle collision on one register.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= 8'h00;
         end
         readdata_q <= '0;
      end else begin
         if (chipselect && write) begin
            regs_q[address] <= writedata[7:0];
         end
         if (i2cWe) begin
            regs_q[ptr_q] <= rxByte;
         end
         if (chipselect && read) begin
            readdata_q <= {24'h0, regs_q[address]};
         end
      end
   end

   assign readdata = readdata_q;
   assign sda_out  = sdaOut_q;

endmodule

// File: tb/tb_iic_slave_core.sv
// Directed bench for iic_slave_core: a bit-banged I2C master plus Avalon accesses,
// with every expected value written out by hand.
module tb_iic_slave_core;

   localparam int Q = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  address;
   logic        chipselect;
   logic        write;
   logic [31:0] writedata;
   logic        read;
   logic [31:0] readdata;
   logic        sclDrv;
   logic        sdaDrv;
   logic        sda_in;
   logic        sda_out;

   int passCount  = 0;
   int checkCount = 0;
   int lowCount   = 0;
   int lowBase;

   logic        ack;
   logic        rel;
   logic [7:0]  rdByte;
   logic [31:0] rd32;

   always #5 clk = ~clk;

   // Open-drain bus: either side may pull SDA low.
   assign sda_in = sdaDrv & sda_out;

   always @(posedge clk) begin
      if (sda_out === 1'b0) lowCount <= lowCount + 1;
   end

   iic_slave_core #(.DEV_ADDR(7'h50), .REG_AW(4)) dut (
      .clk(clk),
      .rst(rst),
      .address(address),
      .chipselect(chipselect),
      .write(write),
      .writedata(writedata),
      .read(read),
      .readdata(readdata),
      .scl_in(sclDrv),
      .sda_in(sda_in),
      .sda_out(sda_out)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   task automatic waitClk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic avWrite(input logic [3:0] a, input logic [7:0] d);
      address = a; writedata = {24'hDEADBE, d}; chipselect = 1'b1; write = 1'b1;
      @(posedge clk); #1;
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic avRead(input logic [3:0] a, output logic [31:0] d);
      address = a; chipselect = 1'b1; read = 1'b1;
      @(posedge clk); #1;
      chipselect = 1'b0; read = 1'b0;
      d = readdata;
   endtask

   task automatic checkReg(input string tag, input logic [3:0] a, input logic [7:0] expected);
      logic [31:0] d;
      avRead(a, d);
      checkOutput(tag, d, {24'h0, expected});
   endtask

   task automatic i2cStart();
      sdaDrv = 1'b1; waitClk(Q);
      sclDrv = 1'b1; waitClk(Q);
      sdaDrv = 1'b0; waitClk(Q);
      sclDrv = 1'b0; waitClk(Q);
   endtask

   task automatic i2cStop();
      sdaDrv = 1'b0; waitClk(Q);
      sclDrv = 1'b1; waitClk(Q);
      sdaDrv = 1'b1; waitClk(Q);
   endtask

   // With collide set, an Avalon write of 0x33 to reg7 lands on the clock the
   // core commits the byte: SCL rise + 2 sync stages + 1 edge-detect stage.
   task automatic sendBit(input logic b, input logic collide);
      sdaDrv = b; waitClk(Q);
      sclDrv = 1'b1;
      if (collide) begin
         @(posedge clk); @(posedge clk); #1;
         address = 4'd7; writedata = 32'h0000_0033; chipselect = 1'b1; write = 1'b1;
         @(posedge clk); #1;
         chipselect = 1'b0; write = 1'b0;
         waitClk(2 * Q - 3);
      end else begin
         waitClk(2 * Q);
      end
      sclDrv = 1'b0; waitClk(Q);
   endtask

   task automatic writeByte(input logic [7:0] d, input logic collideLast, output logic gotAck);
      for (int i = 7; i >= 0; i--) sendBit(d[i], collideLast && (i == 0));
      sdaDrv = 1'b1; waitClk(Q);
      sclDrv = 1'b1; waitClk(Q);
      gotAck = (sda_in == 1'b0);
      waitClk(Q);
      sclDrv = 1'b0; waitClk(Q);
   endtask

   task automatic readByte(input logic masterAck, output logic [7:0] d, output logic slotReleased);
      sdaDrv = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         waitClk(Q);
         sclDrv = 1'b1; waitClk(Q);
         d[i] = sda_in;
         waitClk(Q);
         sclDrv = 1'b0; waitClk(Q);
      end
      sdaDrv = masterAck ? 1'b0 : 1'b1; waitClk(Q);
      sclDrv = 1'b1; waitClk(Q);
      slotReleased = sda_out;
      waitClk(Q);
      sclDrv = 1'b0; waitClk(Q);
   endtask

   initial begin
      #500_000;
      $display("[TB] FAIL watchdog: time limit reached before the end of the run");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      rst = 1'b1; sclDrv = 1'b1; sdaDrv = 1'b1;
      address = '0; chipselect = 1'b0; write = 1'b0; read = 1'b0; writedata = '0;
      waitClk(3);
      checkOutput("reset sda_out", 32'(sda_out), 32'h1);
      checkOutput("reset readdata", readdata, 32'h0);
      rst = 1'b0;
      waitClk(2);
      checkReg("reset reg3", 4'd3, 8'h00);

      $display("[TB] test 1: I2C write of two bytes");
      i2cStart();
      writeByte(8'hA0, 1'b0, ack); checkOutput("t1 addr ack", 32'(ack), 32'h1);
      writeByte(8'h03, 1'b0, ack); checkOutput("t1 ptr ack", 32'(ack), 32'h1);
      writeByte(8'h11, 1'b0, ack); checkOutput("t1 data0 ack", 32'(ack), 32'h1);
      writeByte(8'h22, 1'b0, ack); checkOutput("t1 data1 ack", 32'(ack), 32'h1);
      i2cStop();
      checkReg("t1 reg3", 4'd3, 8'h11);
      checkReg("t1 reg4", 4'd4, 8'h22);

      $display("[TB] test 2: repeated-start read with pointer wrap");
      avWrite(4'd15, 8'hA5);
      avWrite(4'd0, 8'h5A);
      i2cStart();
      writeByte(8'hA0, 1'b0, ack); checkOutput("t2 addr ack", 32'(ack), 32'h1);
      writeByte(8'h0F, 1'b0, ack); checkOutput("t2 ptr ack", 32'(ack), 32'h1);
      i2cStart();
      writeByte(8'hA1, 1'b0, ack); checkOutput("t2 read addr ack", 32'(ack), 32'h1);
      readByte(1'b1, rdByte, rel);
      checkOutput("t2 byte0", 32'(rdByte), 32'hA5);
      checkOutput("t2 ack slot released", 32'(rel), 32'h1);
      readByte(1'b0, rdByte, rel);
      checkOutput("t2 byte1 wrapped", 32'(rdByte), 32'h5A);
      lowBase = lowCount;
      waitClk(20);
      i2cStop();
      checkOutput("t2 low after nack", 32'(lowCount - lowBase), 32'h0);

      $display("[TB] test 3: foreign address is ignored");
      lowBase = lowCount;
      i2cStart();
      writeByte(8'hA2, 1'b0, ack); checkOutput("t3 addr nack", 32'(ack), 32'h0);
      writeByte(8'h03, 1'b0, ack);
      writeByte(8'h99, 1'b0, ack);
      i2cStop();
      checkOutput("t3 low count", 32'(lowCount - lowBase), 32'h0);
      checkReg("t3 reg3", 4'd3, 8'h11);
      checkReg("t3 reg4", 4'd4, 8'h22);

      $display("[TB] test 4: partial byte discarded");
      avWrite(4'd5, 8'h77);
      avWrite(4'd6, 8'h66);
      i2cStart();
      writeByte(8'hA0, 1'b0, ack); checkOutput("t4 addr ack", 32'(ack), 32'h1);
      writeByte(8'h05, 1'b0, ack); checkOutput("t4 ptr ack", 32'(ack), 32'h1);
      sendBit(1'b1, 1'b0); sendBit(1'b0, 1'b0); sendBit(1'b1, 1'b0); sendBit(1'b0, 1'b0);
      i2cStop();
      checkReg("t4 reg5 unchanged", 4'd5, 8'h77);
      i2cStart();
      writeByte(8'hA1, 1'b0, ack); checkOutput("t4 read addr ack", 32'(ack), 32'h1);
      readByte(1'b1, rdByte, rel); checkOutput("t4 read reg5", 32'(rdByte), 32'h77);
      readByte(1'b0, rdByte, rel); checkOutput("t4 read reg6", 32'(rdByte), 32'h66);
      i2cStop();

      $display("[TB] test 5: reset during a read");
      avWrite(4'd8, 8'h0F);
      avRead(4'd8, rd32); checkOutput("t5 pre readdata", rd32, 32'h0F);
      i2cStart();
      writeByte(8'hA0, 1'b0, ack);
      writeByte(8'h08, 1'b0, ack);
      i2cStart();
      writeByte(8'hA1, 1'b0, ack); checkOutput("t5 read addr ack", 32'(ack), 32'h1);
      checkOutput("t5 driving low", 32'(sda_out), 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("t5 sda_out after rst", 32'(sda_out), 32'h1);
      checkOutput("t5 readdata after rst", readdata, 32'h0);
      sclDrv = 1'b1; waitClk(Q);
      checkReg("t5 reg8 cleared", 4'd8, 8'h00);
      checkReg("t5 reg15 cleared", 4'd15, 8'h00);
      checkReg("t5 reg3 cleared", 4'd3, 8'h00);
      avWrite(4'd0, 8'hC3);
      avWrite(4'd1, 8'h3C);
      i2cStart();
      writeByte(8'hA1, 1'b0, ack);
      readByte(1'b0, rdByte, rel); checkOutput("t5 ptr back to 0", 32'(rdByte), 32'hC3);
      i2cStop();

      $display("[TB] test 6: same-cycle write collision");
      i2cStart();
      writeByte(8'hA0, 1'b0, ack);
      writeByte(8'h07, 1'b0, ack);
      writeByte(8'h44, 1'b1, ack); checkOutput("t6 data ack", 32'(ack), 32'h1);
      i2cStop();
      checkReg("t6 reg7 i2c wins", 4'd7, 8'h44);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
